// File: rtl/mem_io_pkg.sv
// Shared encodings for the data-side memory system: access modes, MMIO offsets
// and TXSTAT bit layout.
package mem_io_pkg;

    localparam logic [2:0] MMD_W  = 3'd0;
    localparam logic [2:0] MMD_H  = 3'd1;
    localparam logic [2:0] MMD_HU = 3'd2;
    localparam logic [2:0] MMD_B  = 3'd3;
    localparam logic [2:0] MMD_BU = 3'd4;

    localparam logic [15:0] OFF_TXDATA = 16'h0000;
    localparam logic [15:0] OFF_TXSTAT = 16'h0004;
    localparam logic [15:0] OFF_CYCLE  = 16'h0008;
    localparam logic [15:0] OFF_HALT   = 16'h000C;

    localparam int TXS_EMPTY   = 0;
    localparam int TXS_FULL    = 1;
    localparam int TXS_OVF     = 2;
    localparam int TXS_CNT_LSB = 3;
    localparam int TXS_CNT_W   = 6;

    // Unknown modes fall back to full-word alignment rules.
    function automatic logic isAligned(input logic [2:0] mode, input logic [1:0] low);
        logic ok;
        case (mode)
            MMD_H, MMD_HU: ok = (low[0] == 1'b0);
            MMD_B, MMD_BU: ok = 1'b1;
            default:       ok = (low == 2'b00);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/data_mem_io_tx_fifo.sv
// TX byte FIFO with registered storage, sticky overflow and count output.
module tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [7:0]               pushData,
    input  logic                     pop,
    input  logic                     clrOverflow,
    output logic [7:0]               head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    store [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic          doPop;
    logic          doPush;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign head  = store[rdPtr];

    assign doPop  = pop && !empty;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign doPush = push && (!full || doPop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            if (doPush && !doPop)      count <= count + 1'b1;
            else if (doPop && !doPush) count <= count - 1'b1;
            if (push && !doPush)  overflow <= 1'b1;
            else if (clrOverflow) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) store[wrPtr] <= pushData;
    end

endmodule

// File: rtl/data_mem_io.sv
// Data-side memory for the CPU MEM stage: word RAM with sub-word access plus an
// MMIO window holding a TX byte FIFO, a free-running cycle counter and a halt flag.
module data_mem_io
    import mem_io_pkg::*;
#(
    parameter int          RAM_WORDS  = 1024,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] dataAddress,
    input  logic [31:0] writeMemData,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [2:0]  memMode,
    output logic [31:0] readMemData,
    output logic [7:0]  txData,
    output logic        txValid,
    input  logic        txReady,
    output logic        halt,
    output logic        memErr
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]       ram [RAM_WORDS];
    logic              isMmio;
    logic [15:0]       mmioOff;
    logic [RAM_AW-1:0] wordIdx;
    logic              aligned;
    logic [31:0]       ramWord;
    logic [15:0]       halfSel;
    logic [7:0]        byteSel;
    logic [3:0]        wrMask;
    logic [31:0]       wrData;
    logic              ramWe;
    logic [31:0]       cycleCnt;
    logic [31:0]       statWord;

    logic              fifoPush;
    logic              fifoPop;
    logic              fifoClrOvf;
    logic              fifoEmpty;
    logic              fifoFull;
    logic              fifoOvf;
    logic [CNT_W-1:0]  fifoCount;

    assign isMmio  = (dataAddress[31:16] == MMIO_BASE[31:16]);
    assign mmioOff = dataAddress[15:0];
    assign wordIdx = dataAddress[RAM_AW+1:2];
    assign aligned = isAligned(memMode, dataAddress[1:0]);
    assign ramWord = ram[wordIdx];
    assign halfSel = dataAddress[1] ? ramWord[31:16] : ramWord[15:0];
    assign byteSel = ramWord[{dataAddress[1:0], 3'b000} +: 8];

    always_comb begin
        statWord = '0;
        statWord[TXS_CNT_LSB +: TXS_CNT_W] = TXS_CNT_W'(fifoCount);
        statWord[TXS_OVF]   = fifoOvf;
        statWord[TXS_FULL]  = fifoFull;
        statWord[TXS_EMPTY] = fifoEmpty;
    end

    // Loads resolve in the same cycle; a store in the same cycle lands at the edge,
    // so a simultaneous read sees the pre-store word.
    always_comb begin
        readMemData = '0;
        if (memRead) begin
            if (isMmio) begin
                case (mmioOff)
                    OFF_TXSTAT: readMemData = statWord;
                    OFF_CYCLE:  readMemData = cycleCnt;
                    OFF_HALT:   readMemData = {31'b0, halt};
                    default:    readMemData = '0;
                endcase
            end else if (aligned) begin
                case (memMode)
                    MMD_H:   readMemData = {{16{halfSel[15]}}, halfSel};
                    MMD_HU:  readMemData = {16'b0, halfSel};
                    MMD_B:   readMemData = {{24{byteSel[7]}}, byteSel};
                    MMD_BU:  readMemData = {24'b0, byteSel};
                    default: readMemData = ramWord;
                endcase
            end
        end
    end

    always_comb begin
        wrMask = 4'hF;
        wrData = writeMemData;
        case (memMode)
            MMD_H, MMD_HU: begin
                wrMask = dataAddress[1] ? 4'b1100 : 4'b0011;
                wrData = {2{writeMemData[15:0]}};
            end
            MMD_B, MMD_BU: begin
                wrMask = 4'b0001 << dataAddress[1:0];
                wrData = {4{writeMemData[7:0]}};
            end
            default: begin
                wrMask = 4'hF;
                wrData = writeMemData;
            end
        endcase
    end

    assign ramWe = memWrite && !isMmio && aligned;

    always_ff @(posedge clk) begin
        if (ramWe) begin
            for (int i = 0; i < 4; i++) begin
                if (wrMask[i]) ram[wordIdx][8*i +: 8] <= wrData[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycleCnt <= '0;
            halt     <= 1'b0;
            memErr   <= 1'b0;
        end else begin
            if (memWrite && isMmio && mmioOff == OFF_CYCLE) cycleCnt <= '0;
            else                                            cycleCnt <= cycleCnt + 32'd1;
            if (memWrite && isMmio && mmioOff == OFF_HALT) halt <= 1'b1;
            if ((memRead || memWrite) && !isMmio && !aligned) memErr <= 1'b1;
        end
    end

    // txValid/txReady: a byte transfers on each rising edge where both are high;
    // txData is stable while txValid is high and txReady is low.
    assign fifoPush   = memWrite && isMmio && (mmioOff == OFF_TXDATA);
    assign fifoClrOvf = memWrite && isMmio && (mmioOff == OFF_TXSTAT);
    assign fifoPop    = txValid && txReady;
    assign txValid    = !fifoEmpty;

    tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) uTxFifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (fifoPush),
        .pushData    (writeMemData[7:0]),
        .pop         (fifoPop),
        .clrOverflow (fifoClrOvf),
        .head        (txData),
        .empty       (fifoEmpty),
        .full        (fifoFull),
        .count       (fifoCount),
        .overflow    (fifoOvf)
    );

endmodule

// File: tb/tb_data_mem_io.sv
// Directed bench for data_mem_io: expected loads and TX bytes go into queues and
// are popped by monitors whenever the DUT presents a load or a TX transfer.
module tb_data_mem_io;
    import mem_io_pkg::*;

    localparam logic [31:0] A_TXDATA = 32'hFFFF0000;
    localparam logic [31:0] A_TXSTAT = 32'hFFFF0004;
    localparam logic [31:0] A_CYCLE  = 32'hFFFF0008;
    localparam logic [31:0] A_HALT   = 32'hFFFF000C;

    logic        clk;
    logic        rst_n;
    logic [31:0] dataAddress;
    logic [31:0] writeMemData;
    logic        memRead;
    logic        memWrite;
    logic [2:0]  memMode;
    logic [31:0] readMemData;
    logic [7:0]  txData;
    logic        txValid;
    logic        txReady;
    logic        halt;
    logic        memErr;

    logic [31:0] exp_q[$];
    logic [7:0]  txExp_q[$];
    int          checks;
    int          errors;

    data_mem_io dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dataAddress  (dataAddress),
        .writeMemData (writeMemData),
        .memRead      (memRead),
        .memWrite     (memWrite),
        .memMode      (memMode),
        .readMemData  (readMemData),
        .txData       (txData),
        .txValid      (txValid),
        .txReady      (txReady),
        .halt         (halt),
        .memErr       (memErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h, required %08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearBus();
        memRead  = 1'b0;
        memWrite = 1'b0;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] mode);
        dataAddress  = addr;
        writeMemData = data;
        memMode      = mode;
        memWrite     = 1'b1;
        memRead      = 1'b0;
        step();
        clearBus();
    endtask

    task automatic load(input logic [31:0] addr, input logic [2:0] mode, input logic [31:0] exp);
        dataAddress = addr;
        memMode     = mode;
        memRead     = 1'b1;
        memWrite    = 1'b0;
        exp_q.push_back(exp);
        step();
        clearBus();
    endtask

    // Read monitor: every cycle with memRead high presents a load result.
    always @(negedge clk) begin
        if (rst_n && memRead) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected load: got %08h, required no load", readMemData);
            end else begin
                check("readMemData", readMemData, exp_q.pop_front());
            end
        end
    end

    // TX monitor: a byte is delivered on every cycle with txValid and txReady high.
    always @(negedge clk) begin
        if (txValid && txReady) begin
            if (txExp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected tx byte: got %02h, required none", txData);
            end else begin
                check("txData", {24'b0, txData}, {24'b0, txExp_q.pop_front()});
            end
        end
    end

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        dataAddress  = '0;
        writeMemData = '0;
        memRead      = 1'b0;
        memWrite     = 1'b0;
        memMode      = MMD_W;
        txReady      = 1'b0;
        #1;
        check("reset txValid", {31'b0, txValid}, 32'd0);
        check("reset halt", {31'b0, halt}, 32'd0);
        check("reset memErr", {31'b0, memErr}, 32'd0);
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Sub-word loads from a full word.
        store(32'h10, 32'h8899AABC, MMD_W);
        load(32'h10, MMD_B,  32'hFFFFFFBC);
        load(32'h10, MMD_BU, 32'h000000BC);
        load(32'h11, MMD_B,  32'hFFFFFFAA);
        load(32'h13, MMD_BU, 32'h00000088);
        load(32'h12, MMD_H,  32'hFFFF8899);
        load(32'h12, MMD_HU, 32'h00008899);
        load(32'h10, MMD_H,  32'hFFFFAABC);
        load(32'h10, MMD_HU, 32'h0000AABC);
        load(32'h10, MMD_W,  32'h8899AABC);
        dataAddress = 32'h10;
        #1;
        check("no read gives 0", readMemData, 32'd0);

        // Sub-word stores, alignment errors, aliasing.
        store(32'h20, 32'hFFFFFFFF, MMD_W);
        store(32'h22, 32'h00001234, MMD_H);
        load(32'h20, MMD_W, 32'h1234FFFF);
        store(32'h21, 32'h00000077, MMD_B);
        load(32'h20, MMD_W, 32'h123477FF);
        check("memErr before misalign", {31'b0, memErr}, 32'd0);
        store(32'h21, 32'hDEADBEEF, MMD_W);
        check("memErr after misaligned store", {31'b0, memErr}, 32'd1);
        load(32'h20, MMD_W, 32'h123477FF);
        load(32'h21, MMD_H, 32'h00000000);
        load(32'h1020, MMD_W, 32'h123477FF);
        check("memErr sticky", {31'b0, memErr}, 32'd1);

        // Simultaneous load and store returns the old word.
        store(32'h30, 32'h11111111, MMD_W);
        dataAddress  = 32'h30;
        writeMemData = 32'h22222222;
        memMode      = MMD_W;
        memRead      = 1'b1;
        memWrite     = 1'b1;
        exp_q.push_back(32'h11111111);
        step();
        clearBus();
        load(32'h30, MMD_W, 32'h22222222);

        // Overflow: 9 pushes with the consumer stalled.
        txReady = 1'b0;
        for (int i = 0; i < 9; i++) begin
            store(A_TXDATA, 32'h41 + i, MMD_W);
            if (i < 8) txExp_q.push_back(8'(8'h41 + i));
        end
        check("txValid when full", {31'b0, txValid}, 32'd1);
        load(A_TXSTAT, MMD_W, 32'h00000046);
        store(A_TXSTAT, 32'h0, MMD_W);
        load(A_TXSTAT, MMD_W, 32'h00000042);
        txReady = 1'b1;
        repeat (8) step();
        check("drain complete txValid", {31'b0, txValid}, 32'd0);
        check("drain all bytes seen", txExp_q.size(), 32'd0);

        // No bypass: pushing into an empty FIFO shows txValid only next cycle.
        txExp_q.push_back(8'h60);
        store(A_TXDATA, 32'h60, MMD_W);
        check("txValid after push", {31'b0, txValid}, 32'd1);
        step();
        check("single byte drained", {31'b0, txValid}, 32'd0);

        // Push into a full FIFO while popping.
        txReady = 1'b0;
        for (int i = 0; i < 8; i++) begin
            store(A_TXDATA, 32'h41 + i, MMD_W);
            txExp_q.push_back(8'(8'h41 + i));
        end
        txExp_q.push_back(8'h5A);
        txReady = 1'b1;
        store(A_TXDATA, 32'h5A, MMD_W);
        txReady = 1'b0;
        load(A_TXSTAT, MMD_W, 32'h00000042);
        txReady = 1'b1;
        repeat (8) step();
        check("full+pop drain txValid", {31'b0, txValid}, 32'd0);
        check("full+pop all bytes seen", txExp_q.size(), 32'd0);
        txReady = 1'b0;

        // Cycle counter: clear, then 5 cycles apart.
        store(A_CYCLE, 32'hABCD, MMD_W);
        load(A_CYCLE, MMD_W, 32'd0);
        repeat (4) step();
        load(A_CYCLE, MMD_W, 32'd5);
        force dut.cycleCnt = 32'hFFFFFFFF;
        #2;
        release dut.cycleCnt;
        step();
        load(A_CYCLE, MMD_W, 32'd0);

        // Halt register.
        check("halt before write", {31'b0, halt}, 32'd0);
        store(A_HALT, 32'h0, MMD_W);
        check("halt set", {31'b0, halt}, 32'd1);
        repeat (3) step();
        check("halt persists", {31'b0, halt}, 32'd1);
        load(A_HALT, MMD_W, 32'd1);
        load(32'hFFFF0040, MMD_W, 32'd0);

        // Reset mid-drain.
        for (int i = 0; i < 3; i++) begin
            store(A_TXDATA, 32'h71 + i, MMD_W);
            txExp_q.push_back(8'(8'h71 + i));
        end
        txReady = 1'b1;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset txValid", {31'b0, txValid}, 32'd0);
        check("async reset halt", {31'b0, halt}, 32'd0);
        check("async reset memErr", {31'b0, memErr}, 32'd0);
        txExp_q.delete();
        repeat (2) step();
        rst_n = 1'b1;
        step();
        check("post reset txValid", {31'b0, txValid}, 32'd0);
        load(32'h10, MMD_W, 32'h8899AABC);
        load(32'h20, MMD_W, 32'h123477FF);
        load(A_TXSTAT, MMD_W, 32'h00000001);
        step();
        check("load queue drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
